// File: rtl/sl_pkg.sv
// Shared definitions for the load/store request path.
//   - Store-Load Type field encodings and the store-select bit index
//   - sl_is_legal(): true for the eight supported load/store codes
//   - state_e: request controller states
package sl_pkg;

  localparam logic [2:0] SL_B  = 3'b000;
  localparam logic [2:0] SL_H  = 3'b001;
  localparam logic [2:0] SL_W  = 3'b010;
  localparam logic [2:0] SL_BU = 3'b100;
  localparam logic [2:0] SL_HU = 3'b101;

  localparam int unsigned SL_STORE_BIT = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    RESP
  } state_e;

  // Stores have no unsigned variants, so only b/h/w are legal with the store bit set.
  function automatic logic sl_is_legal(input logic [3:0] sltype);
    logic [2:0] kind;
    kind = sltype[2:0];
    if (sltype[SL_STORE_BIT]) begin
      return (kind == SL_B) || (kind == SL_H) || (kind == SL_W);
    end
    return (kind == SL_B) || (kind == SL_H) || (kind == SL_W) ||
           (kind == SL_BU) || (kind == SL_HU);
  endfunction

endpackage

// File: rtl/sl_lane_align.sv
// Combinational lane alignment for the load/store controller.
//   sl_kind   : Store-Load Type [2:0] (size and signedness)
//   off       : byte offset within the word
//   wdata     : right-justified store data
//   r64       : {second word, first word} read data (second word 0 if single)
//   be64      : byte enables across the two-word window
//   wd64      : store data placed on its byte lanes across the two-word window
//   rdata_ext : load result, realigned and sign/zero extended
module sl_lane_align
  import sl_pkg::*;
(
  input  logic [2:0]  sl_kind,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [63:0] r64,
  output logic [7:0]  be64,
  output logic [63:0] wd64,
  output logic [31:0] rdata_ext
);

  logic [3:0]  size_mask;
  logic [31:0] shifted;

  always_comb begin
    case (sl_kind[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase

    be64    = {4'b0000, size_mask} << off;
    wd64    = {32'b0, wdata} << {off, 3'b000};
    shifted = 32'(r64 >> {off, 3'b000});

    case (sl_kind)
      SL_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      SL_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      SL_W:    rdata_ext = shifted;
      SL_BU:   rdata_ext = {24'b0, shifted[7:0]};
      SL_HU:   rdata_ext = {16'b0, shifted[15:0]};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_request_ctrl.sv
// Load/store request controller between the memory stage and word memory.
// Accepts one command at a time, splits misaligned accesses into two word
// transactions and returns a merged, extended load result.
//   req_*  : command handshake (addr, right-justified wdata, Store-Load Type)
//   rsp_*  : one-cycle completion pulse with load data and illegal-type error
//   mem_*  : word-memory request/grant and read-data return
module lsu_request_ctrl
  import sl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_sltype,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [3:0]        sltype_q, sltype_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        be_hi_q, be_hi_d;
  logic [31:0]       wd_hi_q, wd_hi_d;
  logic [31:0]       rd0_q, rd0_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic [2:0]        al_kind;
  logic [1:0]        al_off;
  logic [31:0]       al_wdata;
  logic [63:0]       al_r64;
  logic [7:0]        al_be64;
  logic [63:0]       al_wd64;
  logic [31:0]       al_rdata;
  logic              split;

  // One aligner serves both directions: lane placement is only needed on
  // accept (IDLE, fed from the request), extension only in the WAIT states
  // (fed from the captured type/offset).
  assign al_kind  = (state_q == IDLE) ? req_sltype[2:0] : sltype_q[2:0];
  assign al_off   = (state_q == IDLE) ? req_addr[1:0]   : off_q;
  assign al_wdata = req_sltype[SL_STORE_BIT] ? req_wdata : '0;
  assign al_r64   = (state_q == WAIT1) ? {mem_rdata, rd0_q} : {32'b0, mem_rdata};
  assign split    = (be_hi_q != 4'b0000);

  sl_lane_align u_align (
    .sl_kind   (al_kind),
    .off       (al_off),
    .wdata     (al_wdata),
    .r64       (al_r64),
    .be64      (al_be64),
    .wd64      (al_wd64),
    .rdata_ext (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    sltype_d    = sltype_q;
    off_d       = off_q;
    base_d      = base_q;
    be_hi_d     = be_hi_q;
    wd_hi_d     = wd_hi_q;
    rd0_d       = rd0_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          sltype_d = req_sltype;
          off_d    = req_addr[1:0];
          base_d   = {req_addr[ADDR_W-1:2], 2'b00};
          be_hi_d  = al_be64[7:4];
          wd_hi_d  = al_wd64[63:32];
          if (sl_is_legal(req_sltype)) begin
            state_d     = ISSUE0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_sltype[SL_STORE_BIT];
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = al_be64[3:0];
            mem_wdata_d = al_wd64[31:0];
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ISSUE0: begin
        if (mem_gnt) begin
          if (sltype_q[SL_STORE_BIT] && split) begin
            state_d     = ISSUE1;
            mem_addr_d  = base_q + ADDR_W'(4);
            mem_be_d    = be_hi_q;
            mem_wdata_d = wd_hi_q;
          end else if (!sltype_q[SL_STORE_BIT]) begin
            state_d   = WAIT0;
            mem_req_d = 1'b0;
          end else begin
            state_d     = RESP;
            mem_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
          end
        end
      end
      WAIT0: begin
        if (mem_rvalid) begin
          rd0_d = mem_rdata;
          if (split) begin
            state_d     = ISSUE1;
            mem_req_d   = 1'b1;
            mem_addr_d  = base_q + ADDR_W'(4);
            mem_be_d    = be_hi_q;
            mem_wdata_d = wd_hi_q;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = al_rdata;
          end
        end
      end
      ISSUE1: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (!sltype_q[SL_STORE_BIT]) begin
            state_d = WAIT1;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end
      WAIT1: begin
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = al_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sltype_q    <= '0;
      off_q       <= '0;
      base_q      <= '0;
      be_hi_q     <= '0;
      wd_hi_q     <= '0;
      rd0_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sltype_q    <= sltype_d;
      off_q       <= off_d;
      base_q      <= base_d;
      be_hi_q     <= be_hi_d;
      wd_hi_q     <= wd_hi_d;
      rd0_q       <= rd0_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_request_ctrl.sv
// Self-checking bench for lsu_request_ctrl: directed cases followed by random
// transactions against a byte-addressed reference memory.
module tb_lsu_request_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sltype;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_request_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_sltype (req_sltype),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] wmem    [16];  // memory as seen over the bus (64 bytes)
  logic [7:0]  ref_mem [64];  // reference byte memory

  logic [31:0] got_rd;
  logic        got_err;
  int          got_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke_word(input int a, input logic [31:0] d);
    wmem[a / 4] = d;
    for (int j = 0; j < 4; j++) ref_mem[(a / 4) * 4 + j] = d[8*j +: 8];
  endtask

  function automatic bit ref_legal(input logic [3:0] t);
    case (t)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int size_of(input logic [3:0] t);
    case (t[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Expected enables/data for word k of an access, derived byte by byte.
  task automatic exp_lane(input int a, input int n, input logic [31:0] wd, input int k,
                          output logic [3:0] be, output logic [31:0] wv);
    int base;
    int p;
    base = (a / 4) * 4 + 4 * k;
    be = '0;
    wv = '0;
    for (int j = 0; j < 4; j++) begin
      p = base + j;
      if (p >= a && p < a + n) begin
        be[j] = 1'b1;
        wv[8*j +: 8] = wd[8*(p - a) +: 8];
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  // g: grant delay per word, r: extra cycles before rvalid after the cycle following grant.
  task automatic run_txn(input int a, input logic [31:0] wd, input logic [3:0] t,
                         input int g, input int r);
    bit          legal;
    bit          st;
    int          n;
    int          exp_words;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic [31:0] val;
    int          nw;
    int          waitc;
    bit          pend;
    int          cd;
    logic [31:0] pend_data;
    bit          done;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [67:0] snap;
    int          idx;

    legal = ref_legal(t);
    st    = t[3];
    n     = size_of(t);
    exp_words = legal ? ((a % 4) + n + 3) / 4 : 0;
    exp_rd = '0;
    if (legal && !st) begin
      val = '0;
      for (int i = 0; i < n; i++) val = val | (32'(ref_mem[a + i]) << (8 * i));
      exp_rd = val;
      if (!t[2] && n < 4 && val[8*n - 1]) exp_rd = val - (32'd1 << (8 * n));
    end
    if (!legal)  exp_lat = 1;
    else if (st) exp_lat = 1 + exp_words * (g + 1);
    else         exp_lat = 1 + exp_words * (g + r + 2);

    chk("ready_idle", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_addr   = 32'(a);
    req_wdata  = wd;
    req_sltype = t;
    nw = 0; waitc = 0; pend = 0; cd = 0; pend_data = '0; done = 0; snap = '0;
    got_rd = '0; got_err = 1'b0; got_lat = 0;

    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      req_valid  = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (pend) begin
        if (cd == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend_data;
          pend       = 0;
        end else begin
          cd--;
        end
      end
      if (rsp_valid) begin
        got_rd  = rsp_rdata;
        got_err = rsp_err;
        got_lat = cyc;
        done    = 1;
      end else if (mem_req) begin
        if (waitc == 0) snap = {mem_we, mem_be, mem_addr, mem_wdata};
        else chk("mem_stable", 64'({mem_we, mem_be, mem_addr, mem_wdata} ^ snap), 64'd0);
        if (waitc < g) begin
          waitc++;
          // Stray read data while a request is still waiting for grant.
          if (!pend && !mem_rvalid && $urandom_range(1) == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
          end
        end else begin
          mem_gnt = 1'b1;
          exp_lane(a, n, wd, nw, ebe, ewd);
          chk("word_addr", 64'(mem_addr), 64'((a / 4) * 4 + 4 * nw));
          chk("word_we", 64'(mem_we), 64'(st));
          chk("word_be", 64'(mem_be), 64'(ebe));
          idx = int'(mem_addr[5:2]);
          if (st) begin
            chk("word_wdata", 64'(mem_wdata & {{8{ebe[3]}}, {8{ebe[2]}}, {8{ebe[1]}}, {8{ebe[0]}}}),
                64'(ewd));
            for (int j = 0; j < 4; j++)
              if (mem_be[j]) wmem[idx][8*j +: 8] = mem_wdata[8*j +: 8];
          end else begin
            pend      = 1;
            cd        = r;
            pend_data = wmem[idx];
          end
          nw++;
          waitc = 0;
        end
      end
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;

    if (!done) begin
      chk("rsp_timeout", 64'd0, 64'd1);
    end else begin
      chk("rsp_err", 64'(got_err), 64'(!legal));
      chk("rsp_rdata", 64'(got_rd), 64'(exp_rd));
      chk("latency", 64'(got_lat), 64'(exp_lat));
      chk("word_count", 64'(nw), 64'(exp_words));
      @(posedge clk);
      @(negedge clk);
      chk("rsp_pulse", 64'(rsp_valid), 64'd0);
    end

    if (legal && st) begin
      for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
      for (int k = 0; k < exp_words; k++) begin
        idx = a / 4 + k;
        chk("mem_content", 64'(wmem[idx]),
            64'({ref_mem[idx*4+3], ref_mem[idx*4+2], ref_mem[idx*4+1], ref_mem[idx*4]}));
      end
    end
  endtask

  logic [3:0]  legal_codes [8];
  logic [67:0] rsnap;

  initial begin
    legal_codes = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_sltype = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    for (int w = 0; w < 16; w++) poke_word(w * 4, $urandom);

    // Reset values
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'd0);
    chk("rst_mem_ctl", 64'({mem_req, mem_we, mem_be}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Aligned sw 0x10 <- 0xDEADBEEF
    run_txn(32'h10, 32'hDEADBEEF, 4'b1010, 0, 0);
    chk("sw_latency", 64'(got_lat), 64'd2);
    chk("sw_word", 64'(wmem[4]), 64'hDEADBEEF);

    // lb / lbu at 0x13 of 0x80FF7F01
    poke_word(32'h10, 32'h80FF7F01);
    run_txn(32'h13, '0, 4'b0000, 0, 0);
    chk("lb_value", 64'(got_rd), 64'hFFFFFF80);
    chk("lb_latency", 64'(got_lat), 64'd3);
    run_txn(32'h13, '0, 4'b0100, 0, 0);
    chk("lbu_value", 64'(got_rd), 64'h00000080);

    // Misaligned lw 0x6 across 0x4/0x8
    poke_word(32'h4, 32'h44332211);
    poke_word(32'h8, 32'h88776655);
    run_txn(32'h6, '0, 4'b0010, 0, 0);
    chk("lw_split_value", 64'(got_rd), 64'h66554433);
    chk("lw_split_latency", 64'(got_lat), 64'd5);

    // Misaligned sh 0x7 <- 0xABCD
    run_txn(32'h7, 32'h0000ABCD, 4'b1001, 0, 0);
    chk("sh_split_w0", 64'(wmem[1][31:24]), 64'hCD);
    chk("sh_split_w1", 64'(wmem[2][7:0]), 64'hAB);

    // Illegal type
    run_txn(32'h20, '0, 4'b0011, 0, 0);
    chk("illegal_err", 64'(got_err), 64'd1);
    chk("illegal_latency", 64'(got_lat), 64'd1);

    // Grant withheld 3 cycles, then reset mid-transaction
    req_valid  = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    req_sltype = 4'b1010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold_req", 64'(mem_req), 64'd1);
    rsnap = {mem_we, mem_be, mem_addr, mem_wdata};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_stable", 64'({mem_we, mem_be, mem_addr, mem_wdata} ^ rsnap), 64'd0);
      chk("hold_req_high", 64'(mem_req), 64'd1);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_mem_req", 64'(mem_req), 64'd0);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_no_rsp", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    run_txn(32'h20, '0, 4'b0010, 0, 0);

    // Random traffic with random grant/rvalid delays
    for (int it = 0; it < 60; it++) begin
      logic [3:0] t;
      if ($urandom_range(9) < 8) t = legal_codes[$urandom_range(7)];
      else t = 4'($urandom_range(15));
      run_txn(int'($urandom_range(59)), $urandom, t,
              int'($urandom_range(3)), int'($urandom_range(3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
